// File: rtl/dpram_bist_pkg.sv
// Shared encodings for the dual-port RAM March C- BIST: FSM states, march
// element numbering and per-element direction / read / write data selects.
// Latency: n/a (constants only). Backpressure: n/a.
package dpram_bist_pkg;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_WR   = 3'd1;
  localparam state_t S_RD   = 3'd2;
  localparam state_t S_CMP  = 3'd3;
  localparam state_t S_DONE = 3'd4;

  typedef logic [2:0] elem_t;
  localparam elem_t M0 = 3'd0;
  localparam elem_t M1 = 3'd1;
  localparam elem_t M2 = 3'd2;
  localparam elem_t M3 = 3'd3;
  localparam elem_t M4 = 3'd4;
  localparam elem_t M5 = 3'd5;

  // Bit e describes element e. Direction: 1 = ascending address order.
  localparam logic [7:0] ELEM_UP = 8'b0000_0111;
  // Expected-data select for the read op: 1 = ~BACKGROUND (r1 in M2, M4).
  localparam logic [7:0] RD_SEL  = 8'b0001_0100;
  // Write-data select for the write op: 1 = ~BACKGROUND (w1 in M1, M3).
  localparam logic [7:0] WR_SEL  = 8'b0000_1010;

endpackage

// File: rtl/dpram_march_bist_if.sv
// RAM pin bundle between the BIST (master) and the dual-port RAM (slave).
// Ports: A address/data/strobes, B address/data/strobes, B read data, conflict.
// Latency: wires only. Backpressure: none.
interface dpram_march_bist_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_in_a;
  logic                  write_en_a;
  logic                  read_en_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_in_b;
  logic                  write_en_b;
  logic                  read_en_b;
  logic [DATA_WIDTH-1:0] data_out_b;
  logic                  conflict_flag;

  modport master (
    output addr_a, data_in_a, write_en_a, read_en_a,
    output addr_b, data_in_b, write_en_b, read_en_b,
    input  data_out_b, conflict_flag
  );

  modport slave (
    input  addr_a, data_in_a, write_en_a, read_en_a,
    input  addr_b, data_in_b, write_en_b, read_en_b,
    output data_out_b, conflict_flag
  );
endinterface

// File: rtl/dpram_bist_errlog.sv
// Read-data compare, saturating error counter and first-failure capture.
// Ports: clr/cmp_en controls, compare address/element/data in; counters out.
// Latency: miscompare is combinational, logged state updates on the CMP edge.
// Backpressure: none.
module dpram_bist_errlog
  import dpram_bist_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     cmp_en,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  elem_t                    elem,
  input  logic [DATA_WIDTH-1:0]    exp_data,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     miscompare,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    fail_addr,
  output elem_t                    fail_elem,
  output logic [DATA_WIDTH-1:0]    fail_data
);

  assign miscompare = cmp_en && (rd_data != exp_data);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      err_count <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else if (miscompare) begin
      if (err_count != '1)
        err_count <= err_count + ERR_CNT_WIDTH'(1);
      // Counter never wraps, so zero means nothing has been logged yet.
      if (err_count == '0) begin
        fail_addr <= addr;
        fail_elem <= elem;
        fail_data <= rd_data;
      end
    end
  end

endmodule

// File: rtl/dpram_march_bist.sv
// March C- BIST driving an async dual-port RAM: A writes, B reads, 15*D cycles.
// Ports: clk/reset/start, ram master bundle, busy/done/pass/conflict status,
// first-fail address/element/data and err_count. All outputs registered.
// Backpressure: none; start is ignored while busy.
module dpram_march_bist
  import dpram_bist_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDR_WIDTH    = 4,
  parameter int                    MEM_DEPTH     = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND    = DATA_WIDTH'(8'h55),
  parameter bit                    STOP_ON_FAIL  = 1'b0,
  parameter int                    ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  dpram_march_bist_if.master       ram,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     conflict_seen,
  output logic [ADDR_WIDTH-1:0]    fail_addr,
  output logic [2:0]               fail_elem,
  output logic [DATA_WIDTH-1:0]    fail_data,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                state, state_n;
  elem_t                 elem, elem_n, elem_inc;
  logic [ADDR_WIDTH-1:0] addr, addr_n, addr_step, addr_first;
  logic                  at_end, start_acc, miscompare;
  logic [DATA_WIDTH-1:0] exp_data;

  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
  logic [DATA_WIDTH-1:0] data_a_q;
  logic                  we_a_q, re_b_q;

  assign start_acc  = start && (state == S_IDLE || state == S_DONE);
  assign at_end     = ELEM_UP[elem] ? (addr == LAST_ADDR) : (addr == '0);
  assign addr_step  = ELEM_UP[elem] ? addr + ADDR_WIDTH'(1) : addr - ADDR_WIDTH'(1);
  assign elem_inc   = elem + 3'd1;
  assign addr_first = ELEM_UP[elem_inc] ? '0 : LAST_ADDR;
  assign exp_data   = RD_SEL[elem] ? ~BACKGROUND : BACKGROUND;

  always_comb begin
    state_n = state;
    elem_n  = elem;
    addr_n  = addr;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_WR;
          elem_n  = M0;
          addr_n  = '0;
        end
      end
      S_WR: begin
        // Every element after M0 opens with a read, so an element change
        // always lands in RD at that element's first address.
        if (at_end) begin
          state_n = S_RD;
          elem_n  = elem_inc;
          addr_n  = addr_first;
        end else begin
          state_n = (elem == M0) ? S_WR : S_RD;
          addr_n  = addr_step;
        end
      end
      S_RD: state_n = S_CMP;
      S_CMP: begin
        if (STOP_ON_FAIL && miscompare)
          state_n = S_DONE;
        else if (elem != M5)
          state_n = S_WR;
        else if (at_end)
          state_n = S_DONE;
        else begin
          state_n = S_RD;
          addr_n  = addr_step;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pin registers are loaded from next-state values so the RAM sees the
  // strobes in the same cycle the FSM sits in WR/RD/CMP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      elem          <= M0;
      addr          <= '0;
      we_a_q        <= 1'b0;
      addr_a_q      <= '0;
      data_a_q      <= '0;
      re_b_q        <= 1'b0;
      addr_b_q      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      conflict_seen <= 1'b0;
    end else begin
      state    <= state_n;
      elem     <= elem_n;
      addr     <= addr_n;
      we_a_q   <= (state_n == S_WR);
      addr_a_q <= (state_n == S_WR) ? addr_n : '0;
      data_a_q <= (state_n != S_WR) ? '0 :
                  (WR_SEL[elem_n] ? ~BACKGROUND : BACKGROUND);
      re_b_q   <= (state_n == S_RD || state_n == S_CMP);
      addr_b_q <= (state_n == S_RD || state_n == S_CMP) ? addr_n : '0;
      busy     <= (state_n == S_WR || state_n == S_RD || state_n == S_CMP);
      done     <= (state_n == S_DONE);
      if (start_acc)
        conflict_seen <= 1'b0;
      else if (ram.conflict_flag && busy)
        conflict_seen <= 1'b1;
      // Pass resolves on the finishing edge, folding in this edge's compare
      // and conflict sample since their registers update on the same edge.
      if (start_acc)
        pass <= 1'b0;
      else if (state == S_CMP && state_n == S_DONE)
        pass <= !miscompare && (err_count == '0) && !conflict_seen &&
                !(ram.conflict_flag && busy);
    end
  end

  dpram_bist_errlog #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_errlog (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_acc),
    .cmp_en    (state == S_CMP),
    .addr      (addr),
    .elem      (elem),
    .exp_data  (exp_data),
    .rd_data   (ram.data_out_b),
    .miscompare(miscompare),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data)
  );

  assign ram.addr_a     = addr_a_q;
  assign ram.data_in_a  = data_a_q;
  assign ram.write_en_a = we_a_q;
  assign ram.read_en_a  = 1'b0;
  assign ram.addr_b     = addr_b_q;
  assign ram.data_in_b  = '0;
  assign ram.write_en_b = 1'b0;
  assign ram.read_en_b  = re_b_q;

endmodule

// File: tb/tb_dpram_march_bist.sv
// Bench for dpram_march_bist: behavioural 16x8 RAMs, one fault-free-capable
// DUT and one STOP_ON_FAIL DUT with a stuck-at-1 on bit1 of address 5.
// Expected results are queued at stimulus time and popped as the DUT reports.
module tb_dpram_march_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start0, start1, conf0, fault0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  dpram_march_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) ram0 ();
  dpram_march_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) ram1 ();

  logic       busy0, done0, pass0, cs0, busy1, done1, pass1, cs1;
  logic [3:0] fa0, fa1;
  logic [2:0] fe0, fe1;
  logic [7:0] fd0, fd1, ec0, ec1;

  dpram_march_bist #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .ram(ram0),
    .busy(busy0), .done(done0), .pass(pass0), .conflict_seen(cs0),
    .fail_addr(fa0), .fail_elem(fe0), .fail_data(fd0), .err_count(ec0)
  );

  dpram_march_bist #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ram(ram1),
    .busy(busy1), .done(done1), .pass(pass1), .conflict_seen(cs1),
    .fail_addr(fa1), .fail_elem(fe1), .fail_data(fd1), .err_count(ec1)
  );

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  always @(posedge clk) if (ram0.write_en_a) mem0[ram0.addr_a] <= ram0.data_in_a;
  always @(posedge clk) if (ram1.write_en_a) mem1[ram1.addr_a] <= ram1.data_in_a;
  assign ram0.data_out_b    = mem0[ram0.addr_b] |
                              ((fault0 && ram0.addr_b == 4'd5) ? 8'h02 : 8'h00);
  assign ram1.data_out_b    = mem1[ram1.addr_b] | ((ram1.addr_b == 4'd5) ? 8'h02 : 8'h00);
  assign ram0.conflict_flag = conf0;
  assign ram1.conflict_flag = 1'b0;

  logic [54:0] outs0, outs1;
  assign outs0 = {busy0, done0, pass0, cs0, fa0, fe0, fd0, ec0,
                  ram0.addr_a, ram0.data_in_a, ram0.write_en_a, ram0.read_en_a,
                  ram0.addr_b, ram0.data_in_b, ram0.write_en_b, ram0.read_en_b};
  assign outs1 = {busy1, done1, pass1, cs1, fa1, fe1, fd1, ec1,
                  ram1.addr_a, ram1.data_in_a, ram1.write_en_a, ram1.read_en_a,
                  ram1.addr_b, ram1.data_in_b, ram1.write_en_b, ram1.read_en_b};

  typedef struct {
    int         cycles;
    logic       pass;
    logic       cs;
    logic [7:0] err;
    logic [3:0] fa;
    logic [2:0] fe;
    logic [7:0] fd;
  } res_t;

  res_t        exp_q[$];
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];

  // Starts dut0 and follows it to done; collects cycles, writes, violations.
  task automatic run0(input int mid_start, input int conf_at,
                      output int took, output int nwr, output int nviol);
    int t0;
    int k;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); t0 = cyc; start0 = 1'b0;
    nwr = 0; nviol = 0; took = -1; k = 0;
    while (k <= 400) begin
      k = cyc - t0;
      if (ram0.write_en_a) nwr++;
      if ((ram0.write_en_a && ram0.read_en_b) || ram0.write_en_b || ram0.read_en_a) nviol++;
      if (done0) begin took = k; break; end
      start0 = (k == mid_start - 1);
      conf0  = (k == conf_at - 1);
      @(negedge clk);
    end
    start0 = 1'b0;
    conf0  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; conf0 = 1'b0; fault0 = 1'b0;
    for (int i = 0; i < 16; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    repeat (3) @(negedge clk);
    total++;
    if (outs0 !== 55'd0) begin bad++; $display("FAIL reset_dut0 got=%h want=0", outs0); end
    total++;
    if (outs1 !== 55'd0) begin bad++; $display("FAIL reset_dut1 got=%h want=0", outs1); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (outs0 !== 55'd0) begin bad++; $display("FAIL idle_dut0 got=%h want=0", outs0); end
  endtask

  task automatic test_fault_free();
    int t0, k, took, nwr, nviol;
    logic [11:0] w;
    logic [3:0]  a;
    res_t        r;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < 16; i++) begin
        a = (e <= 2) ? 4'(i) : 4'(15 - i);
        if (e >= 1) begin rd_q.push_back(a); rd_q.push_back(a); end
        if (e <= 4) wr_q.push_back({a, (e % 2 == 0) ? 8'h55 : 8'hAA});
      end
    exp_q.push_back('{240, 1'b1, 1'b0, 8'd0, 4'd0, 3'd0, 8'd0});
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); t0 = cyc; start0 = 1'b0;
    nwr = 0; nviol = 0; took = -1; k = 0;
    while (k <= 400) begin
      k = cyc - t0;
      if (done0) begin took = k; break; end
      if ((ram0.write_en_a && ram0.read_en_b) || ram0.write_en_b || ram0.read_en_a) nviol++;
      if (ram0.write_en_a) begin
        nwr++;
        total++;
        if (wr_q.size() == 0) begin
          bad++; $display("FAIL wr_extra got=%h want=none", {ram0.addr_a, ram0.data_in_a});
        end else begin
          w = wr_q.pop_front();
          if ({ram0.addr_a, ram0.data_in_a} !== w) begin
            bad++; $display("FAIL wr_seq cyc=%0d got=%h want=%h", k, {ram0.addr_a, ram0.data_in_a}, w);
          end
        end
      end
      if (ram0.read_en_b) begin
        total++;
        if (rd_q.size() == 0) begin
          bad++; $display("FAIL rd_extra got=%0d want=none", ram0.addr_b);
        end else begin
          a = rd_q.pop_front();
          if (ram0.addr_b !== a) begin
            bad++; $display("FAIL rd_seq cyc=%0d got=%0d want=%0d", k, ram0.addr_b, a);
          end
        end
      end
      @(negedge clk);
    end
    r = exp_q.pop_front();
    total++;
    if (took !== r.cycles) begin bad++; $display("FAIL ff_done_edge got=%0d want=%0d", took, r.cycles); end
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL ff_busy got=%b want=0", busy0); end
    total++;
    if (pass0 !== r.pass || ec0 !== r.err) begin
      bad++; $display("FAIL ff_status got=%b/%0d want=%b/%0d", pass0, ec0, r.pass, r.err);
    end
    total++;
    if (nwr !== 80) begin bad++; $display("FAIL ff_writes got=%0d want=80", nwr); end
    total++;
    if (nviol !== 0) begin bad++; $display("FAIL ff_overlap got=%0d want=0", nviol); end
    total++;
    if (wr_q.size() + rd_q.size() !== 0) begin
      bad++; $display("FAIL ff_missing got=%0d want=0", wr_q.size() + rd_q.size());
    end
    repeat (3) @(negedge clk);
    total++;
    if (done0 !== 1'b1 || pass0 !== 1'b1) begin
      bad++; $display("FAIL ff_sticky got=%b%b want=11", done0, pass0);
    end
    wr_q.delete(); rd_q.delete();
  endtask

  task automatic test_stuck_at();
    int took, nwr, nviol;
    res_t r;
    fault0 = 1'b1;
    exp_q.push_back('{240, 1'b0, 1'b0, 8'd3, 4'd5, 3'd1, 8'h57});
    run0(-1, -1, took, nwr, nviol);
    r = exp_q.pop_front();
    total++;
    if (took !== r.cycles) begin bad++; $display("FAIL sa_done_edge got=%0d want=%0d", took, r.cycles); end
    total++;
    if (ec0 !== r.err) begin bad++; $display("FAIL sa_err got=%0d want=%0d", ec0, r.err); end
    total++;
    if ({fa0, fe0, fd0} !== {r.fa, r.fe, r.fd}) begin
      bad++; $display("FAIL sa_first got=%0d/%0d/%h want=%0d/%0d/%h", fa0, fe0, fd0, r.fa, r.fe, r.fd);
    end
    total++;
    if (pass0 !== r.pass || cs0 !== r.cs) begin
      bad++; $display("FAIL sa_pass got=%b/%b want=%b/%b", pass0, cs0, r.pass, r.cs);
    end
    fault0 = 1'b0;
  endtask

  task automatic test_stop_on_fail();
    int t0, k, took;
    res_t r;
    exp_q.push_back('{33, 1'b0, 1'b0, 8'd1, 4'd5, 3'd1, 8'h57});
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); t0 = cyc; start1 = 1'b0;
    took = -1; k = 0;
    while (k <= 400) begin
      k = cyc - t0;
      if (done1) begin took = k; break; end
      @(negedge clk);
    end
    r = exp_q.pop_front();
    total++;
    if (took !== r.cycles) begin bad++; $display("FAIL sof_done_edge got=%0d want=%0d", took, r.cycles); end
    total++;
    if (ec1 !== r.err || busy1 !== 1'b0 || pass1 !== r.pass) begin
      bad++; $display("FAIL sof_status got=%0d/%b/%b want=%0d/0/%b", ec1, busy1, pass1, r.err, r.pass);
    end
    total++;
    if ({fa1, fe1, fd1} !== {r.fa, r.fe, r.fd}) begin
      bad++; $display("FAIL sof_first got=%0d/%0d/%h want=%0d/%0d/%h", fa1, fe1, fd1, r.fa, r.fe, r.fd);
    end
  endtask

  task automatic test_reset_mid_run();
    int t0, k, took, strobes;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); t0 = cyc; start0 = 1'b0;
    k = 0;
    while (k < 99) begin @(negedge clk); k = cyc - t0; end
    reset = 1'b1;
    @(negedge clk); k = cyc - t0;
    total++;
    if (k !== 100 || outs0 !== 55'd0) begin
      bad++; $display("FAIL rst100 edge=%0d got=%h want=0", k, outs0);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (outs0 !== 55'd0) begin bad++; $display("FAIL rst101 got=%h want=0", outs0); end
    strobes = 0;
    repeat (3) begin
      @(negedge clk);
      if (ram0.write_en_a || ram0.read_en_b || busy0) strobes++;
    end
    total++;
    if (strobes !== 0) begin bad++; $display("FAIL rst_quiet got=%0d want=0", strobes); end
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; k = cyc - t0;
    total++;
    if (k !== 105 || busy0 !== 1'b1) begin
      bad++; $display("FAIL rst_restart edge=%0d busy=%b want=105/1", k, busy0);
    end
    took = -1;
    while (k <= 800) begin
      k = cyc - t0;
      if (done0) begin took = k; break; end
      @(negedge clk);
    end
    total++;
    if (took !== 345 || pass0 !== 1'b1) begin
      bad++; $display("FAIL rst_done got=%0d/%b want=345/1", took, pass0);
    end
  endtask

  task automatic test_conflict();
    int took, nwr, nviol;
    res_t r;
    exp_q.push_back('{240, 1'b0, 1'b1, 8'd0, 4'd0, 3'd0, 8'd0});
    run0(-1, 50, took, nwr, nviol);
    r = exp_q.pop_front();
    total++;
    if (took !== r.cycles) begin bad++; $display("FAIL cf_done_edge got=%0d want=%0d", took, r.cycles); end
    total++;
    if (cs0 !== r.cs || pass0 !== r.pass || ec0 !== r.err) begin
      bad++; $display("FAIL cf_status got=%b/%b/%0d want=%b/%b/%0d", cs0, pass0, ec0, r.cs, r.pass, r.err);
    end
  endtask

  task automatic test_start_while_busy();
    int took, nwr, nviol;
    res_t r;
    exp_q.push_back('{240, 1'b1, 1'b0, 8'd0, 4'd0, 3'd0, 8'd0});
    run0(120, -1, took, nwr, nviol);
    r = exp_q.pop_front();
    total++;
    if (took !== r.cycles || nwr !== 80) begin
      bad++; $display("FAIL swb_run got=%0d/%0d want=%0d/80", took, nwr, r.cycles);
    end
    total++;
    if (pass0 !== r.pass || ec0 !== r.err || cs0 !== r.cs) begin
      bad++; $display("FAIL swb_status got=%b/%0d/%b want=%b/%0d/%b", pass0, ec0, cs0, r.pass, r.err, r.cs);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_stop_on_fail();
    test_reset_mid_run();
    test_conflict();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
